forward_scheduler: RTL

FORWARD_SCHEDULER -- requirements
Module: forward_scheduler

---
 rtl/forward_sched_pkg.sv | 46 ++++
 rtl/fwd_slot_match.sv | 28 ++
 rtl/forward_scheduler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/forward_sched_pkg.sv
// -----------------------------------------------------------------------------
// forward_sched_pkg
// Shared types for the operand-forwarding scheduler: the in-flight writer
// table entry, the width of its load countdown, and a saturating-at-zero
// decrement helper.
// Register-file geometry (REG_ADDR_W, REG_W, REG_N) normally comes from the
// project-wide common parameter header; the guarded defaults below keep
// this slice buildable on its own.
// -----------------------------------------------------------------------------
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef REG_W
`define REG_W 32
`endif
`ifndef REG_N
`define REG_N 32
`endif

package forward_sched_pkg;

  // Width of the load countdown; LOAD_EXE_LAT must fit in it (max 15).
  localparam int LOAD_CNT_W = 4;

  typedef struct packed {
    logic                   valid;
    logic [`REG_ADDR_W-1:0] addr;
    logic [LOAD_CNT_W-1:0]  load_cnt;
  } fwd_entry_t;

  localparam fwd_entry_t FWD_ENTRY_EMPTY = '{
    valid:    1'b0,
    addr:     {`REG_ADDR_W{1'b0}},
    load_cnt: {LOAD_CNT_W{1'b0}}
  };

  // Count a pending load down by one, holding at zero.
  function automatic logic [LOAD_CNT_W-1:0] load_cnt_dec(input logic [LOAD_CNT_W-1:0] cnt);
    if (cnt != {LOAD_CNT_W{1'b0}}) begin
      return cnt - {{(LOAD_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/fwd_slot_match.sv
// -----------------------------------------------------------------------------
// fwd_slot_match
// Compares one writer-table entry against the three operand addresses of
// the decode head.
// Ports:
//   valid_i            entry holds a live writer
//   addr_i             destination register of that writer
//   addr_d/s/t_i       operand register addresses at the decode head
//   match_o[2:0]       {t, s, d} hit bits (valid entry, equal address)
// -----------------------------------------------------------------------------
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module fwd_slot_match (
  input  logic                   valid_i,
  input  logic [`REG_ADDR_W-1:0] addr_i,
  input  logic [`REG_ADDR_W-1:0] addr_d_i,
  input  logic [`REG_ADDR_W-1:0] addr_s_i,
  input  logic [`REG_ADDR_W-1:0] addr_t_i,
  output logic [2:0]             match_o
);

  assign match_o = {valid_i & (addr_i == addr_t_i),
                    valid_i & (addr_i == addr_s_i),
                    valid_i & (addr_i == addr_d_i)};

endmodule

// File: rtl/forward_scheduler.sv
// -----------------------------------------------------------------------------
// forward_scheduler
// Tracks in-flight register writers in a shift table (slot E, then write-back
// slots W[0..EW_LAYER]) and tells the decode head where each of its operands
// must be forwarded from, or that it must bubble on a load-use hazard.
// Optional feature macro: FORWARD_SCHEDULER_STATS_EN adds two saturating
// 32-bit event counters (stall cycles, cycles with any forward).
// Ports:
//   clk, rstn                 clock (rising) and async active-low reset
//   dec_valid                 decode head holds a real instruction
//   dec_reg_addr_d/s/t        head register addresses
//   dec_read_d/s/t            head reads that operand
//   dec_write_d, dec_is_load  head writes reg d / result comes from memory
//   flush, ext_stall          squash head / downstream freeze
//   forward_to_x_from_exe     operand x taken from the exe result
//   forward_to_x_from_wri     one-hot write-back layer operand x is taken from
//   stall                     decode must emit a bubble this cycle
//   stat_stall_cycles, stat_forwards   (stats build only)
// -----------------------------------------------------------------------------
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif

module forward_scheduler
  import forward_sched_pkg::*;
#(
  parameter int EW_LAYER     = 1,
  parameter int LOAD_EXE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   dec_valid,
  input  logic [`REG_ADDR_W-1:0] dec_reg_addr_d,
  input  logic [`REG_ADDR_W-1:0] dec_reg_addr_s,
  input  logic [`REG_ADDR_W-1:0] dec_reg_addr_t,
  input  logic                   dec_read_d,
  input  logic                   dec_read_s,
  input  logic                   dec_read_t,
  input  logic                   dec_write_d,
  input  logic                   dec_is_load,
  input  logic                   flush,
  input  logic                   ext_stall,
  output logic                   forward_to_d_from_exe,
  output logic                   forward_to_s_from_exe,
  output logic                   forward_to_t_from_exe,
  output logic [EW_LAYER:0]      forward_to_d_from_wri,
  output logic [EW_LAYER:0]      forward_to_s_from_wri,
  output logic [EW_LAYER:0]      forward_to_t_from_wri,
  output logic                   stall
`ifdef FORWARD_SCHEDULER_STATS_EN
  ,
  output logic [31:0]            stat_stall_cycles,
  output logic [31:0]            stat_forwards
`endif
);

  fwd_entry_t                e_q, e_d;
  fwd_entry_t                w_q [EW_LAYER+1];
  fwd_entry_t                w_d [EW_LAYER+1];

  logic [2:0]                match_e_s;
  logic [EW_LAYER:0][2:0]    match_w_s;
  logic [2:0]                rd_s;
  logic [2:0]                hazard_s;
  logic [2:0]                exe_s;
  logic [2:0]                blocked_s;
  logic [2:0][EW_LAYER:0]    wri_s;
  logic                      load_pending_s;
  logic                      stall_s;
  logic                      issue_s;

  // Operand hits against the youngest slot.
  fwd_slot_match u_match_e (
    .valid_i  (e_q.valid),
    .addr_i   (e_q.addr),
    .addr_d_i (dec_reg_addr_d),
    .addr_s_i (dec_reg_addr_s),
    .addr_t_i (dec_reg_addr_t),
    .match_o  (match_e_s)
  );

  for (genvar gi = 0; gi <= EW_LAYER; gi++) begin : g_match_w
    fwd_slot_match u_match_w (
      .valid_i  (w_q[gi].valid),
      .addr_i   (w_q[gi].addr),
      .addr_d_i (dec_reg_addr_d),
      .addr_s_i (dec_reg_addr_s),
      .addr_t_i (dec_reg_addr_t),
      .match_o  (match_w_s[gi])
    );
  end

  // Forward selection and load-use detection, youngest slot wins.
  always_comb begin
    rd_s           = {dec_read_t, dec_read_s, dec_read_d} & {3{dec_valid}};
    load_pending_s = (e_q.load_cnt != {LOAD_CNT_W{1'b0}});
    hazard_s       = rd_s & match_e_s & {3{load_pending_s}};
    // A squashed head never bubbles.
    stall_s        = (|hazard_s) & ~flush;
    // A load still counting down in E has no result to forward yet.
    exe_s          = rd_s & match_e_s & {3{~load_pending_s}};
    // Any younger hit masks all older layers for that operand.
    blocked_s      = match_e_s;
    wri_s          = {(3*(EW_LAYER+1)){1'b0}};
    for (int i = 0; i <= EW_LAYER; i++) begin
      for (int k = 0; k < 3; k++) begin
        wri_s[k][i] = rd_s[k] & match_w_s[i][k] & ~blocked_s[k];
      end
      blocked_s = blocked_s | match_w_s[i];
    end
  end

  assign issue_s = dec_valid & ~stall_s & ~flush & ~ext_stall;

  // Table next state: shift on a free cycle, freeze (but age the load) on ext_stall.
  always_comb begin
    e_d = e_q;
    w_d = w_q;
    if (ext_stall) begin
      e_d.load_cnt = load_cnt_dec(e_q.load_cnt);
    end else begin
      e_d.valid    = issue_s & dec_write_d;
      e_d.addr     = dec_reg_addr_d;
      e_d.load_cnt = dec_is_load ? LOAD_CNT_W'(LOAD_EXE_LAT) : {LOAD_CNT_W{1'b0}};
      w_d[0]       = e_q;
      for (int i = 1; i <= EW_LAYER; i++) begin
        w_d[i] = w_q[i-1];
      end
    end
  end

  // Writer table registers; reset forgets every in-flight entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      e_q <= FWD_ENTRY_EMPTY;
      for (int i = 0; i <= EW_LAYER; i++) begin
        w_q[i] <= FWD_ENTRY_EMPTY;
      end
    end else begin
      e_q <= e_d;
      for (int i = 0; i <= EW_LAYER; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign forward_to_d_from_exe = exe_s[0];
  assign forward_to_s_from_exe = exe_s[1];
  assign forward_to_t_from_exe = exe_s[2];
  assign forward_to_d_from_wri = wri_s[0];
  assign forward_to_s_from_wri = wri_s[1];
  assign forward_to_t_from_wri = wri_s[2];
  assign stall                 = stall_s;

`ifdef FORWARD_SCHEDULER_STATS_EN
  logic [31:0] stat_stall_q;
  logic [31:0] stat_fwd_q;
  logic        any_fwd_s;

  assign any_fwd_s = (|exe_s) | (|wri_s);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_stall_q <= 32'd0;
      stat_fwd_q   <= 32'd0;
    end else begin
      if (stall_s && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end else begin
        stat_stall_q <= stat_stall_q;
      end
      if (any_fwd_s && (stat_fwd_q != 32'hFFFF_FFFF)) begin
        stat_fwd_q <= stat_fwd_q + 32'd1;
      end else begin
        stat_fwd_q <= stat_fwd_q;
      end
    end
  end

  assign stat_stall_cycles = stat_stall_q;
  assign stat_forwards     = stat_fwd_q;
`endif

endmodule
